project_io_mux: RTL and testbench

Parametrised multi-project I/O arbiter for the user area. It sits between the Caravel pads/logic-analyser and N wrapped user projects, replacing the per-project `active` wiring with one registered selector. It grants the pads to exactly one project at a time and inserts a tristated guard interval on every handover. Illegal multi-select requests are flagged and park the pads safely.

---
 rtl/project_io_mux_pkg.sv | 19 +
 rtl/project_io_mux_onehot_to_index.sv | 38 +++
 rtl/project_io_mux.sv | 144 ++++++++++++++
 tb/tb_project_io_mux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/project_io_mux_pkg.sv
// Shared types and constants for the multi-project pad arbiter.
package project_io_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_VALID,
        REQ_CONFLICT
    } req_kind_t;

    localparam int unsigned SWITCH_COUNT_W = 8;
    localparam logic [SWITCH_COUNT_W-1:0] SWITCH_COUNT_MAX = 8'd255;

endpackage

// File: rtl/project_io_mux_onehot_to_index.sv
// Combinational decode of a request vector into an index and a request kind.
module onehot_to_index
    import project_io_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx_c,
    output req_kind_t        kind_c
);

    logic found;
    logic multi;

    always_comb begin
        idx_c = '0;
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (vec[i]) begin
                if (found) begin
                    multi = 1'b1;
                end
                found = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
        if (multi) begin
            kind_c = REQ_CONFLICT;
        end else if (found) begin
            kind_c = REQ_VALID;
        end else begin
            kind_c = REQ_NONE;
        end
    end

endmodule

// File: rtl/project_io_mux.sv
// Grants the user pads and LA bank to one wrapped project at a time,
// with a tristated guard interval on every handover.
module project_io_mux
    import project_io_mux_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS = 8,
    parameter int unsigned IO_WIDTH     = 38,
    parameter int unsigned LA_WIDTH     = 32,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n,
    input  logic [NUM_PROJECTS-1:0]          active,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb,
    input  logic [NUM_PROJECTS*LA_WIDTH-1:0] proj_la_out,
    output logic [NUM_PROJECTS-1:0]          proj_en,
    output logic [IO_WIDTH-1:0]              io_out,
    output logic [IO_WIDTH-1:0]              io_oeb,
    output logic [LA_WIDTH-1:0]              la_data_out,
    output logic [$clog2(NUM_PROJECTS)-1:0]  sel,
    output logic                             granted,
    output logic                             conflict,
    output logic [SWITCH_COUNT_W-1:0]        switch_count
);

    localparam int unsigned SEL_W = $clog2(NUM_PROJECTS);
    localparam int unsigned CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [NUM_PROJECTS-1:0] req_q;
    logic [SEL_W-1:0]  tgt_q, tgt_d;
    logic              tgt_vld_q, tgt_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [SEL_W-1:0]  req_idx;
    req_kind_t         req_kind;
    logic              dec_vld;
    logic              tgt_changed;

    logic [IO_WIDTH-1:0] io_arr  [NUM_PROJECTS];
    logic [IO_WIDTH-1:0] oeb_arr [NUM_PROJECTS];
    logic [LA_WIDTH-1:0] la_arr  [NUM_PROJECTS];

    onehot_to_index #(
        .WIDTH (NUM_PROJECTS),
        .IDX_W (SEL_W)
    ) u_req_decode (
        .vec    (req_q),
        .idx_c  (req_idx),
        .kind_c (req_kind)
    );

    // Conflicting requests target nothing, same as an empty request.
    assign dec_vld     = (req_kind == REQ_VALID);
    assign tgt_changed = (dec_vld != tgt_vld_q) || (dec_vld && (req_idx != tgt_q));
    assign conflict    = (req_kind == REQ_CONFLICT);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            tgt_q        <= '0;
            tgt_vld_q    <= 1'b0;
            cnt_q        <= '0;
            switch_count <= '0;
            proj_en      <= '0;
            sel          <= '0;
            granted      <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= active;
            tgt_q     <= tgt_d;
            tgt_vld_q <= tgt_vld_d;
            cnt_q     <= cnt_d;
            granted   <= (state_d == RUN);
            sel       <= (state_d == RUN) ? tgt_d : '0;
            proj_en   <= (state_d == RUN) ? (NUM_PROJECTS'(1) << tgt_d) : '0;
            if ((state_d == RUN) && (state_q != RUN) && (switch_count != SWITCH_COUNT_MAX)) begin
                switch_count <= switch_count + SWITCH_COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        tgt_vld_d = tgt_vld_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (dec_vld) begin
                    tgt_d     = req_idx;
                    tgt_vld_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = GUARD;
                end
            end
            GUARD: begin
                if (tgt_changed) begin
                    tgt_d     = dec_vld ? req_idx : '0;
                    tgt_vld_d = dec_vld;
                    cnt_d     = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = tgt_vld_q ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (tgt_changed) begin
                    tgt_d     = dec_vld ? req_idx : '0;
                    tgt_vld_d = dec_vld;
                    cnt_d     = CNT_LOAD;
                    state_d   = GUARD;
                end
            end
            default: begin
                state_d   = IDLE;
                tgt_vld_d = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < int'(NUM_PROJECTS); k++) begin : g_slice
        assign io_arr[k]  = proj_io_out[k*IO_WIDTH +: IO_WIDTH];
        assign oeb_arr[k] = proj_io_oeb[k*IO_WIDTH +: IO_WIDTH];
        assign la_arr[k]  = proj_la_out[k*LA_WIDTH +: LA_WIDTH];
    end

    // Zero-latency data path; pads stay tristated outside RUN.
    always_comb begin
        io_out      = '0;
        io_oeb      = '1;
        la_data_out = '0;
        if (state_q == RUN) begin
            io_out      = io_arr[sel];
            io_oeb      = oeb_arr[sel];
            la_data_out = la_arr[sel];
        end
    end

endmodule

// File: tb/tb_project_io_mux.sv
// Scoreboard bench for project_io_mux: expectations are queued with a due
// cycle when stimulus is driven and checked on the falling edge of that cycle.
module tb_project_io_mux;

    localparam int unsigned NP  = 8;
    localparam int unsigned IOW = 38;
    localparam int unsigned LAW = 32;
    localparam int unsigned G   = 4;
    localparam int unsigned SW  = $clog2(NP);
    localparam logic [63:0] OEB_ONES = (64'd1 << IOW) - 64'd1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     active;
    logic [NP*IOW-1:0] proj_io_out;
    logic [NP*IOW-1:0] proj_io_oeb;
    logic [NP*LAW-1:0] proj_la_out;
    logic [NP-1:0]     proj_en;
    logic [IOW-1:0]    io_out;
    logic [IOW-1:0]    io_oeb;
    logic [LAW-1:0]    la_data_out;
    logic [SW-1:0]     sel;
    logic              granted;
    logic              conflict;
    logic [7:0]        switch_count;

    typedef enum int {S_GRANTED, S_SEL, S_PROJEN, S_IOOUT, S_IOOEB, S_LA, S_CONFLICT, S_COUNT} sig_e;
    typedef struct {
        int unsigned at;
        sig_e        sig;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    project_io_mux #(
        .NUM_PROJECTS (NP),
        .IO_WIDTH     (IOW),
        .LA_WIDTH     (LAW),
        .GUARD_CYCLES (G)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .active       (active),
        .proj_io_out  (proj_io_out),
        .proj_io_oeb  (proj_io_oeb),
        .proj_la_out  (proj_la_out),
        .proj_en      (proj_en),
        .io_out       (io_out),
        .io_oeb       (io_oeb),
        .la_data_out  (la_data_out),
        .sel          (sel),
        .granted      (granted),
        .conflict     (conflict),
        .switch_count (switch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IOW-1:0] io_pat(input int k);
        return IOW'(64'h00_1234_5678 * 64'(k + 1) + 64'h20_0000_0000);
    endfunction

    function automatic logic [IOW-1:0] oeb_pat(input int k);
        return IOW'(64'h15_5555_5500 | 64'(k));
    endfunction

    function automatic logic [LAW-1:0] la_pat(input int k);
        return LAW'(32'hC0DE_0000 | 32'(k));
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] sig_val(input sig_e s);
        case (s)
            S_GRANTED:  return 64'(granted);
            S_SEL:      return 64'(sel);
            S_PROJEN:   return 64'(proj_en);
            S_IOOUT:    return 64'(io_out);
            S_IOOEB:    return 64'(io_oeb);
            S_LA:       return 64'(la_data_out);
            S_CONFLICT: return 64'(conflict);
            default:    return 64'(switch_count);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check_eq(sb[i].tag, sig_val(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned at, input sig_e s, input logic [63:0] v, input string tag);
        exp_t e;
        e.at  = at;
        e.sig = s;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_released(input int unsigned at, input string tag);
        expect_at(at, S_GRANTED, 64'd0,    {tag, "_granted"});
        expect_at(at, S_SEL,     64'd0,    {tag, "_sel"});
        expect_at(at, S_PROJEN,  64'd0,    {tag, "_proj_en"});
        expect_at(at, S_IOOUT,   64'd0,    {tag, "_io_out"});
        expect_at(at, S_IOOEB,   OEB_ONES, {tag, "_io_oeb"});
        expect_at(at, S_LA,      64'd0,    {tag, "_la"});
    endtask

    // Request driven after edge 'base' reaches RUN at edge base+G+2.
    task automatic expect_grant(input int unsigned base, input int idx, input int unsigned cnt, input string tag);
        expect_at(base + G + 1, S_GRANTED, 64'd0, {tag, "_not_yet"});
        expect_at(base + G + 2, S_GRANTED, 64'd1, {tag, "_granted"});
        expect_at(base + G + 2, S_SEL,     64'(idx), {tag, "_sel"});
        expect_at(base + G + 2, S_PROJEN,  64'd1 << idx, {tag, "_proj_en"});
        expect_at(base + G + 2, S_IOOUT,   64'(io_pat(idx)), {tag, "_io_out"});
        expect_at(base + G + 2, S_IOOEB,   64'(oeb_pat(idx)), {tag, "_io_oeb"});
        expect_at(base + G + 2, S_LA,      64'(la_pat(idx)), {tag, "_la"});
        expect_at(base + G + 2, S_COUNT,   64'(cnt), {tag, "_count"});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned s;
        rst_n  = 1'b0;
        active = '0;
        for (int k = 0; k < int'(NP); k++) begin
            proj_io_out[k*IOW +: IOW] = io_pat(k);
            proj_io_oeb[k*IOW +: IOW] = oeb_pat(k);
            proj_la_out[k*LAW +: LAW] = la_pat(k);
        end
        step(3);

        // Idle after reset with no request.
        rst_n = 1'b1;
        n = cyc;
        expect_released(n, "rst");
        expect_at(n, S_COUNT, 64'd0, "rst_count");
        expect_at(n, S_CONFLICT, 64'd0, "rst_conflict");
        expect_released(n + 10, "idle10");
        expect_at(n + 10, S_COUNT, 64'd0, "idle10_count");
        step(11);

        // First grant to project 2.
        n = cyc;
        active = 8'h04;
        expect_released(n + 2, "g2_guard");
        expect_grant(n, 2, 1, "g2");
        step(G + 4);

        // Handover 2 -> 5 with a full tristated guard.
        n = cyc;
        active = 8'h20;
        expect_at(n + 1, S_SEL, 64'd2, "h5_still_run");
        for (int i = 2; i <= 5; i++) expect_released(n + i, "h5_guard");
        expect_grant(n, 5, 2, "h5");
        step(G + 4);

        // Conflict parks the pads; a clean request recovers.
        n = cyc;
        active = 8'h03;
        expect_at(n + 1, S_CONFLICT, 64'd1, "cf_flag");
        expect_released(n + 2, "cf_guard");
        expect_released(n + 8, "cf_idle");
        expect_at(n + 8, S_CONFLICT, 64'd1, "cf_level");
        step(10);
        n = cyc;
        active = 8'h02;
        expect_at(n + 1, S_CONFLICT, 64'd0, "cf_clear");
        expect_grant(n, 1, 3, "cf_g1");
        step(G + 4);

        // Target change with cnt == 1 restarts the whole guard.
        n = cyc;
        active = 8'h04;
        expect_at(n + 4, S_GRANTED, 64'd0, "rs_cnt1");
        step(4);
        s = cyc;
        active = 8'h08;
        expect_released(s + 2, "rs_no_old");
        expect_grant(s, 3, 4, "rs_g3");
        step(G + 4);

        // Reset mid-RUN, then re-grant with the request still held.
        n = cyc;
        active = 8'h04;
        expect_grant(n, 2, 5, "pre_rst");
        step(G + 4);
        s = cyc;
        rst_n = 1'b0;
        expect_released(s + 1, "mid_rst");
        expect_at(s + 1, S_COUNT, 64'd0, "mid_rst_count");
        expect_at(s + 1, S_CONFLICT, 64'd0, "mid_rst_conflict");
        step(1);
        rst_n = 1'b1;
        expect_grant(s + 1, 2, 1, "post_rst");
        step(G + 5);

        step(2);
        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
